// File: rtl/alu_sequencer.sv
// Issue stage for the registered ALU: decodes one instruction, drives A/B/control, writes the result back.
// Latency: ALU ops write back 4 edges after accept (ALU_LAT=2); LDI/illegal resolve at the accept edge.
// Backpressure: instr_ready is high only in IDLE; the source holds instr until it is accepted.
module alu_sequencer #(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  output logic             done,
  output logic             err,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] rf [NREGS];
  logic [1:0]       rd_q;

  logic [3:0] op;
  logic [1:0] rd, rs, rt;
  logic       acc_alu, acc_ldi, acc_ill, wb;

  assign op = instr[15:12];
  assign rd = instr[11:10];
  assign rs = instr[9:8];
  assign rt = instr[7:6];

  assign instr_ready = (state == IDLE);
  assign dbg_data    = rf[dbg_sel];

  // WAIT spans the ALU input-capture edge plus ALU_LAT update edges.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_alu = 1'b0;
    acc_ldi = 1'b0;
    acc_ill = 1'b0;
    wb      = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (op == 4'b0010) begin
            acc_ldi = 1'b1;
          end else if (op inside {[4'b0011:4'b0111]}) begin
            acc_ill = 1'b1;
          end else begin
            acc_alu = 1'b1;
            state_n = WAIT;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(ALU_LAT)) state_n = WB;
        else                     cnt_n   = cnt + 1'b1;
      end
      WB: begin
        wb      = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= wb | acc_ldi;
      err   <= acc_ill;
      if (acc_alu) begin
        alu_a       <= rf[rs];
        alu_b       <= rf[rt];
        alu_control <= op;
        rd_q        <= rd;
      end
      if (acc_ldi) rf[rd]   <= instr[WIDTH-1:0];
      if (wb)      rf[rd_q] <= alu_out;
    end
  end

endmodule
